wb_debug_serializer: RTL and testbench

- Sits between the core's retire/writeback stage and the SoC-level debug_wb_* port that the trace-compare bench consumes.
- Accepts up to two retired writeback events per cycle from a dual-lane writeback stage and buffers them in order.
- Emits at most one event per cycle on the single-lane debug port, back-pressuring the pipeline with a registered stall.

---
 rtl/wb_debug_serializer.sv | 140 ++++++++++++++
 tb/tb_wb_debug_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_debug_serializer.sv
// rtl/wb_debug_serializer.sv - dual-lane retire events serialized onto the single-lane debug_wb port
// Optional macro WB_DEBUG_DROP_X0_EN: only events writing a nonzero register are enqueued and emitted.
module wb_debug_serializer #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        soc_clk,
  input  logic        resetn,
  input  logic        wb0_valid,
  input  logic [63:0] wb0_pc,
  input  logic        wb0_rf_wen,
  input  logic [4:0]  wb0_rf_wnum,
  input  logic [63:0] wb0_rf_wdata,
  input  logic        wb1_valid,
  input  logic [63:0] wb1_pc,
  input  logic        wb1_rf_wen,
  input  logic [4:0]  wb1_rf_wnum,
  input  logic [63:0] wb1_rf_wdata,
  output logic        wb_stall,
  output logic [63:0] debug_wb_pc,
  output logic [7:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [63:0] debug_wb_rf_wdata,
  output logic [31:0] retire_cnt,
  output logic        overflow
);

  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      r_pc_mem    [DEPTH];
  logic             r_wen_mem   [DEPTH];
  logic [4:0]       r_wnum_mem  [DEPTH];
  logic [63:0]      r_wdata_mem [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_stall;
  logic             r_overflow;
  logic [63:0]      r_dbg_pc;
  logic [7:0]       r_dbg_wen;
  logic [4:0]       r_dbg_wnum;
  logic [63:0]      r_dbg_wdata;
  logic [31:0]      r_retire_cnt;

  logic             w_pop;
  logic             w_req0;
  logic             w_req1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_drop;
  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_next_count;
  logic [PTR_W-1:0] w_tail1;
  logic [4:0]       w_wnum0;
  logic [4:0]       w_wnum1;
  logic [63:0]      w_wdata0;
  logic [63:0]      w_wdata1;

  always_comb begin
    w_pop = (r_count != '0);
`ifdef WB_DEBUG_DROP_X0_EN
    w_req0 = wb0_valid && wb0_rf_wen && (wb0_rf_wnum != 5'd0);
    w_req1 = wb1_valid && wb1_rf_wen && (wb1_rf_wnum != 5'd0);
`else
    w_req0 = wb0_valid;
    w_req1 = wb1_valid;
`endif
    // The slot popped this edge is reusable by a push on the same edge.
    w_free       = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
    w_acc0       = w_req0 && (w_free != '0);
    w_acc1       = w_req1 && (w_free > CNT_W'(w_acc0));
    w_drop       = (w_req0 && !w_acc0) || (w_req1 && !w_acc1);
    w_next_count = r_count + CNT_W'(w_acc0) + CNT_W'(w_acc1) - CNT_W'(w_pop);
    w_tail1      = r_tail + PTR_W'(w_acc0);
    // Non-writing events carry zeroed wnum/wdata so nothing undefined reaches the port.
    w_wnum0      = wb0_rf_wen ? wb0_rf_wnum  : 5'd0;
    w_wnum1      = wb1_rf_wen ? wb1_rf_wnum  : 5'd0;
    w_wdata0     = wb0_rf_wen ? wb0_rf_wdata : 64'd0;
    w_wdata1     = wb1_rf_wen ? wb1_rf_wdata : 64'd0;
  end

  always_ff @(posedge soc_clk) begin
    if (w_acc0) begin
      r_pc_mem[r_tail]    <= wb0_pc;
      r_wen_mem[r_tail]   <= wb0_rf_wen;
      r_wnum_mem[r_tail]  <= w_wnum0;
      r_wdata_mem[r_tail] <= w_wdata0;
    end
    if (w_acc1) begin
      r_pc_mem[w_tail1]    <= wb1_pc;
      r_wen_mem[w_tail1]   <= wb1_rf_wen;
      r_wnum_mem[w_tail1]  <= w_wnum1;
      r_wdata_mem[w_tail1] <= w_wdata1;
    end
  end

  always_ff @(posedge soc_clk) begin
    if (!resetn) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_stall      <= 1'b0;
      r_overflow   <= 1'b0;
      r_dbg_pc     <= 64'd0;
      r_dbg_wen    <= 8'd0;
      r_dbg_wnum   <= 5'd0;
      r_dbg_wdata  <= 64'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_acc0) + PTR_W'(w_acc1);
      r_count <= w_next_count;
      r_stall <= (w_next_count > CNT_W'(DEPTH - 2));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_dbg_pc     <= r_pc_mem[r_head];
        r_dbg_wen    <= {8{r_wen_mem[r_head]}};
        r_dbg_wnum   <= r_wnum_mem[r_head];
        r_dbg_wdata  <= r_wdata_mem[r_head];
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end else begin
        r_dbg_wen   <= 8'd0;
        r_dbg_wnum  <= 5'd0;
        r_dbg_wdata <= 64'd0;
      end
    end
  end

  assign wb_stall          = r_stall;
  assign overflow          = r_overflow;
  assign debug_wb_pc       = r_dbg_pc;
  assign debug_wb_rf_wen   = r_dbg_wen;
  assign debug_wb_rf_wnum  = r_dbg_wnum;
  assign debug_wb_rf_wdata = r_dbg_wdata;
  assign retire_cnt        = r_retire_cnt;

endmodule

// File: tb/tb_wb_debug_serializer.sv
// tb/tb_wb_debug_serializer.sv - self-checking bench for wb_debug_serializer
// Reference model is an event queue; honours WB_DEBUG_DROP_X0_EN when defined.
module tb_wb_debug_serializer;

  localparam int DEPTH = 8;

  typedef struct {
    logic [63:0] pc;
    logic        wen;
    logic [4:0]  wnum;
    logic [63:0] wdata;
  } ev_t;

  logic        soc_clk;
  logic        resetn;
  logic        wb0_valid;
  logic [63:0] wb0_pc;
  logic        wb0_rf_wen;
  logic [4:0]  wb0_rf_wnum;
  logic [63:0] wb0_rf_wdata;
  logic        wb1_valid;
  logic [63:0] wb1_pc;
  logic        wb1_rf_wen;
  logic [4:0]  wb1_rf_wnum;
  logic [63:0] wb1_rf_wdata;
  logic        wb_stall;
  logic [63:0] debug_wb_pc;
  logic [7:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [63:0] debug_wb_rf_wdata;
  logic [31:0] retire_cnt;
  logic        overflow;

  ev_t         q[$];
  logic [63:0] m_pc;
  logic [7:0]  m_wen;
  logic [4:0]  m_wnum;
  logic [63:0] m_wdata;
  logic [31:0] m_cnt;
  logic        m_ovf;
  logic        m_stall;
  int          m_acc;
  int          n_assert;
  int          n_fail;

  wb_debug_serializer #(.DEPTH(DEPTH)) dut (
    .soc_clk(soc_clk), .resetn(resetn),
    .wb0_valid(wb0_valid), .wb0_pc(wb0_pc), .wb0_rf_wen(wb0_rf_wen),
    .wb0_rf_wnum(wb0_rf_wnum), .wb0_rf_wdata(wb0_rf_wdata),
    .wb1_valid(wb1_valid), .wb1_pc(wb1_pc), .wb1_rf_wen(wb1_rf_wen),
    .wb1_rf_wnum(wb1_rf_wnum), .wb1_rf_wdata(wb1_rf_wdata),
    .wb_stall(wb_stall), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt), .overflow(overflow)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit wanted(input logic v, input logic wen, input logic [4:0] wnum);
`ifdef WB_DEBUG_DROP_X0_EN
    return v && wen && (wnum != 5'd0);
`else
    return v;
`endif
  endfunction

  task automatic offer(input logic v, input logic [63:0] pc, input logic wen,
                       input logic [4:0] wnum, input logic [63:0] wdata);
    ev_t ev;
    if (wanted(v, wen, wnum)) begin
      if (q.size() < DEPTH) begin
        ev.pc = pc; ev.wen = wen; ev.wnum = wnum; ev.wdata = wdata;
        q.push_back(ev);
        m_acc++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare all outputs.
  task automatic tick();
    ev_t ev;
    @(posedge soc_clk);
    if (!resetn) begin
      q.delete();
      m_pc = 64'd0; m_wen = 8'd0; m_wnum = 5'd0; m_wdata = 64'd0;
      m_cnt = 32'd0; m_ovf = 1'b0; m_stall = 1'b0;
    end else begin
      if (q.size() != 0) begin
        ev = q.pop_front();
        m_pc    = ev.pc;
        m_wen   = ev.wen ? 8'hff : 8'h00;
        m_wnum  = ev.wen ? ev.wnum : 5'd0;
        m_wdata = ev.wen ? ev.wdata : 64'd0;
        m_cnt   = m_cnt + 32'd1;
      end else begin
        m_wen = 8'd0; m_wnum = 5'd0; m_wdata = 64'd0;
      end
      offer(wb0_valid, wb0_pc, wb0_rf_wen, wb0_rf_wnum, wb0_rf_wdata);
      offer(wb1_valid, wb1_pc, wb1_rf_wen, wb1_rf_wnum, wb1_rf_wdata);
      m_stall = (q.size() > DEPTH - 2);
    end
    #1;
    check("pc", debug_wb_pc, m_pc);
    check("rf_wen", 64'(debug_wb_rf_wen), 64'(m_wen));
    check("rf_wnum", 64'(debug_wb_rf_wnum), 64'(m_wnum));
    check("rf_wdata", debug_wb_rf_wdata, m_wdata);
    check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("wb_stall", 64'(wb_stall), 64'(m_stall));
  endtask

  task automatic set0(input logic v, input logic [63:0] pc, input logic wen,
                      input logic [4:0] wnum, input logic [63:0] wdata);
    wb0_valid = v; wb0_pc = pc; wb0_rf_wen = wen; wb0_rf_wnum = wnum; wb0_rf_wdata = wdata;
  endtask

  task automatic set1(input logic v, input logic [63:0] pc, input logic wen,
                      input logic [4:0] wnum, input logic [63:0] wdata);
    wb1_valid = v; wb1_pc = pc; wb1_rf_wen = wen; wb1_rf_wnum = wnum; wb1_rf_wdata = wdata;
  endtask

  task automatic idle(input int n);
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
  endtask

  task automatic rand_lanes(input bit obey);
    logic v0, v1;
    v0 = 1'($urandom_range(1, 0));
    v1 = 1'($urandom_range(1, 0));
    if (obey && wb_stall) begin v0 = 1'b0; v1 = 1'b0; end
    set0(v0, {$urandom, $urandom}, ($urandom % 4) != 0, 5'($urandom_range(31, 0)), {$urandom, $urandom});
    set1(v1, {$urandom, $urandom}, ($urandom % 4) != 0, 5'($urandom_range(31, 0)), {$urandom, $urandom});
  endtask

  initial begin
    n_assert = 0; n_fail = 0; m_acc = 0;
    resetn = 1'b0;
    set0(1'b0, 64'd0, 1'b0, 5'd0, 64'd0);
    set1(1'b0, 64'd0, 1'b0, 5'd0, 64'd0);
    idle(2);
    check("reset_pc", debug_wb_pc, 64'd0);
    check("reset_cnt", 64'(retire_cnt), 64'd0);
    resetn = 1'b1;
    idle(1);

    // Single event appears one cycle after its enqueue edge.
    set0(1'b1, 64'h8000_0000, 1'b1, 5'd5, 64'h1234);
    tick();
    check("single_early_wen", 64'(debug_wb_rf_wen), 64'h00);
    idle(1);
    check("single_pc", debug_wb_pc, 64'h8000_0000);
    check("single_wen", 64'(debug_wb_rf_wen), 64'hff);
    check("single_wnum", 64'(debug_wb_rf_wnum), 64'd5);
    check("single_wdata", debug_wb_rf_wdata, 64'h1234);
    check("single_cnt", 64'(retire_cnt), 64'd1);
    idle(1);
    check("single_after_wen", 64'(debug_wb_rf_wen), 64'h00);

    // Dual retire ordering.
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, 64'h100, 1'b1, 5'd1, {$urandom, $urandom});
      set1(1'b1, 64'h104, 1'b1, 5'd2, {$urandom, $urandom});
      tick();
    end
    idle(8);
    check("dual_cnt", 64'(retire_cnt), 64'd7);
    check("dual_ovf", 64'(overflow), 64'd0);

    // Pipeline honours stall for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      set0(!wb_stall, {$urandom, $urandom}, 1'b1, 5'($urandom_range(31, 1)), {$urandom, $urandom});
      set1(!wb_stall, {$urandom, $urandom}, 1'b1, 5'($urandom_range(31, 1)), {$urandom, $urandom});
      tick();
    end
    idle(DEPTH + 2);
    check("stall_ovf", 64'(overflow), 64'd0);
    check("stall_cnt", 64'(retire_cnt), 64'(m_acc));

    // x0 / non-writing event handling.
    do_reset();
    set0(1'b1, 64'h200, 1'b1, 5'd0, 64'hdead);
    set1(1'b1, 64'h204, 1'b1, 5'd3, 64'hff);
    tick();
    idle(4);
`ifdef WB_DEBUG_DROP_X0_EN
    check("x0_cnt", 64'(retire_cnt), 64'd1);
`else
    check("x0_cnt", 64'(retire_cnt), 64'd2);
`endif

    // Random traffic that obeys stall.
    for (int i = 0; i < 300; i++) begin
      rand_lanes(1'b1);
      tick();
    end
    idle(DEPTH + 2);
    check("rand_ovf", 64'(overflow), 64'd0);

    // Forced overflow: ignore stall.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set0(1'b1, 64'h1000 + 64'(16 * i), 1'b1, 5'd7, 64'(i));
      set1(1'b1, 64'h1008 + 64'(16 * i), 1'b1, 5'd8, 64'(i + 100));
      tick();
    end
    idle(DEPTH + 4);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset with entries still queued.
    do_reset();
    for (int i = 0; i < 10 && q.size() < 5; i++) begin
      set0(1'b1, {$urandom, $urandom}, 1'b1, 5'd9, {$urandom, $urandom});
      set1(1'b1, {$urandom, $urandom}, 1'b1, 5'd10, {$urandom, $urandom});
      tick();
    end
    check("midrst_fill", 64'(q.size() >= 5), 64'd1);
    do_reset();
    check("midrst_pc", debug_wb_pc, 64'd0);
    check("midrst_cnt", 64'(retire_cnt), 64'd0);
    check("midrst_stall", 64'(wb_stall), 64'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("midrst_no_stale", 64'(debug_wb_rf_wen), 64'h00);
    end

    // Random traffic that sometimes ignores stall.
    for (int i = 0; i < 300; i++) begin
      rand_lanes(($urandom % 4) != 0);
      tick();
    end
    idle(DEPTH + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
